wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
- Parametrised write-back trace recorder; replaces ad-hoc per-cycle pipeline printing with a hardware capture buffer.
- Sits beside the write-back stage and records each retiring instruction (pc, write flag, destination register, result) into a circular buffer of DEPTH entries.
- Capture runs from arm until a PC-match trigger plus a programmable post-trigger count, then freezes.
- The bench or debug logic drains the frozen buffer oldest-first over a valid/ready port.

Parameters:
DEPTH, 16, buffer entries; power of two, >= 2
PC_W, 32, pc width
DATA_W, 32, result width
RA_W, 5, destination register address width
CW, $clog2(DEPTH)+1, width of count/post fields (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  an instruction retires this cycle
in_pc  in  PC_W  pc of retiring instruction
in_w  in  1  register write flag
in_rd  in  RA_W  destination register
in_res  in  DATA_W  result value
arm  in  1  start capture (honoured only in IDLE)
abort  in  1  return to IDLE from any state, discard contents
trig_pc  in  PC_W  trigger pc, sampled on arm
post_cnt  in  CW  entries recorded after trigger entry, sampled on arm, clamped to DEPTH-1
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
count  out  CW  valid entries held, saturates at DEPTH
dropped  out  16  entries overwritten while capturing, saturating
trig_hit  out  1  one-cycle pulse when trigger entry is recorded
rd_valid  out  1  an entry is presented
rd_ready  in  1  consumer accepts entry
rd_pc  out  PC_W  presented entry pc
rd_w  out  1  presented entry write flag
rd_rd  out  RA_W  presented entry destination
rd_res  out  DATA_W  presented entry result
done  out  1  one-cycle pulse when last entry is drained

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, count=0, dropped=0, trig_hit=0, rd_valid=0, done=0, rd_* = 0. Storage contents are don't-care. Reset mid-capture or mid-drain returns to IDLE immediately.
- IDLE:
  - in_valid ignored.
  - arm=1 -> ARMED next cycle; latch trig_pc and post_cnt; clear count, dropped and wr_ptr.
- Recording (ARMED and POST):
  - in_valid=1 writes the entry at wr_ptr; wr_ptr increments mod DEPTH.
  - count increments until it reaches DEPTH.
  - A write when count==DEPTH overwrites the oldest entry and increments dropped (saturates at 16'hFFFF).
  - Latency: an entry is visible in storage the cycle after in_valid.
- ARMED -> POST:
  - Condition: in_valid && in_pc==trig_pc.
  - The trigger entry itself is recorded; trig_hit pulses the following cycle.
  - The post counter loads the latched post_cnt.
  - If post_cnt==0, go directly to FROZEN instead of POST.
- POST:
  - Each in_valid records one entry and decrements the post counter.
  - The record that brings the counter to 0 -> FROZEN.
  - Further pc matches are ignored.
- FROZEN:
  - in_valid ignored; count is held.
  - rd_valid=1 while entries remain. The presented entry is the oldest, at rd_ptr=(wr_ptr-count) mod DEPTH; it is combinational from storage.
  - rd_valid && rd_ready advances rd_ptr and decrements count.
  - When the final entry is accepted: rd_valid drops next cycle, done pulses, state -> IDLE.
  - rd_ready while rd_valid=0 has no effect.
  - rd_* must hold stable while rd_valid && !rd_ready.
- abort (any state) -> IDLE next cycle with count=0 and rd_valid=0. No done pulse.
- Simultaneous events:
  - abort beats arm.
  - arm outside IDLE is ignored.
  - reset beats everything.
- Wrap-around: pointer arithmetic is modulo DEPTH. Drain order stays chronological after any number of wraps.
- Retire during drain: not recorded, and does not perturb rd_*.

Test Plan:
- DEPTH=16; arm with trig_pc=0x40, post_cnt=3; retire pcs 0x00,0x04,...,0x4C (one per cycle) -> trig_hit one cycle after pc 0x40 is recorded; FROZEN after pc 0x4C; count=20 saturated to 16, dropped=4; drain yields pcs 0x10..0x4C in order, then done pulse, state=IDLE.
- Same setup with post_cnt=0 -> FROZEN immediately after pc 0x40; last drained entry is pc 0x40 with matching rd_rd/rd_res.
- Trigger reached after only 5 retires (trig_pc=0x10, post_cnt=2) -> count=7, dropped=0; 7 entries drained oldest-first from pc 0x00.
- Drain with rd_ready toggling 1,0,0,1 -> rd_* stable during stall cycles; no entry skipped or duplicated.
- Abort during POST, and reset asserted mid-drain -> state=IDLE, count=0, rd_valid=0; no done pulse; new arm works normally.
- arm pulsed during ARMED, and in_valid during FROZEN -> ignored; latched trig_pc unchanged, FROZEN count unchanged.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Write-back trace recorder: circular capture of retiring instructions,
// PC-match trigger with post-trigger window, oldest-first valid/ready drain.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid/in_pc/in_w/
//   in_rd/in_res               retiring instruction from write-back
//   arm, abort                 start capture (IDLE only) / discard and go IDLE
//   trig_pc, post_cnt          trigger pc and post-trigger count, sampled on arm
//   state, count, dropped      status: FSM state, entries held, overwrites
//   trig_hit, done             one-cycle pulses: trigger recorded / drain done
//   rd_valid/rd_ready/rd_*     drain port, oldest entry first
module wb_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_w,
   input  logic [RA_W-1:0]   in_rd,
   input  logic [DATA_W-1:0] in_res,
   input  logic              arm,
   input  logic              abort,
   input  logic [PC_W-1:0]   trig_pc,
   input  logic [CW-1:0]     post_cnt,
   output logic [1:0]        state,
   output logic [CW-1:0]     count,
   output logic [15:0]       dropped,
   output logic              trig_hit,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [PC_W-1:0]   rd_pc,
   output logic              rd_w,
   output logic [RA_W-1:0]   rd_rd,
   output logic [DATA_W-1:0] rd_res,
   output logic              done
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_POST   = 2'd2,
      S_FROZEN = 2'd3
   } st_t;

   st_t st_q, st_d;

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [PC_W-1:0]   trig_q;
   logic [CW-1:0]     post_q;
   logic [CW-1:0]     post_ctr;
   logic [CW-1:0]     post_clamp;

   logic [PC_W-1:0]   m_pc  [DEPTH];
   logic              m_w   [DEPTH];
   logic [RA_W-1:0]   m_rd  [DEPTH];
   logic [DATA_W-1:0] m_res [DEPTH];

   logic rec, hit, acc, last;

   assign rec  = in_valid && (st_q == S_ARMED || st_q == S_POST);
   assign hit  = in_valid && st_q == S_ARMED && in_pc == trig_q;
   // Oldest entry sits count slots behind the write pointer; a full
   // buffer (count==DEPTH) wraps this to wr_ptr itself.
   assign rd_ptr   = wr_ptr - count[AW-1:0];
   assign rd_valid = st_q == S_FROZEN && count != '0;
   assign acc  = rd_valid && rd_ready;
   assign last = acc && count == CW'(1);

   assign post_clamp = (post_cnt > CW'(DEPTH - 1)) ? CW'(DEPTH - 1)
                                                   : post_cnt;

   assign state  = st_q;
   assign rd_pc  = rd_valid ? m_pc[rd_ptr]  : '0;
   assign rd_w   = rd_valid ? m_w[rd_ptr]   : 1'b0;
   assign rd_rd  = rd_valid ? m_rd[rd_ptr]  : '0;
   assign rd_res = rd_valid ? m_res[rd_ptr] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) st_q <= S_IDLE;
      else       st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      if (abort) begin
         st_d = S_IDLE;
      end else begin
         unique case (st_q)
            S_IDLE:   if (arm) st_d = S_ARMED;
            S_ARMED:  if (hit) st_d = (post_q == '0) ? S_FROZEN : S_POST;
            S_POST:   if (in_valid && post_ctr == CW'(1)) st_d = S_FROZEN;
            S_FROZEN: if (last) st_d = S_IDLE;
            default:  st_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         count    <= '0;
         dropped  <= '0;
         trig_q   <= '0;
         post_q   <= '0;
         post_ctr <= '0;
         trig_hit <= 1'b0;
         done     <= 1'b0;
      end else begin
         trig_hit <= hit && !abort;
         done     <= last && !abort;
         if (abort) begin
            count <= '0;
         end else if (st_q == S_IDLE) begin
            if (arm) begin
               trig_q  <= trig_pc;
               post_q  <= post_clamp;
               count   <= '0;
               dropped <= '0;
               wr_ptr  <= '0;
            end
         end else if (rec) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != CW'(DEPTH))
               count <= count + CW'(1);
            else if (dropped != 16'hFFFF)
               dropped <= dropped + 16'd1;
            if (hit)
               post_ctr <= post_q;
            else if (st_q == S_POST)
               post_ctr <= post_ctr - CW'(1);
         end else if (acc) begin
            count <= count - CW'(1);
         end
      end
   end

   // Storage needs no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (rec) begin
         m_pc[wr_ptr]  <= in_pc;
         m_w[wr_ptr]   <= in_w;
         m_rd[wr_ptr]  <= in_rd;
         m_res[wr_ptr] <= in_res;
      end
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer (DEPTH=16).
// Scoreboard queue holds expected drain order.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic          in_w;
  logic [4:0]    in_rd;
  logic [31:0]   in_res;
  logic          arm;
  logic          abort;
  logic [31:0]   trig_pc;
  logic [CW-1:0] post_cnt;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [15:0]   dropped;
  logic          trig_hit;
  logic          rd_valid;
  logic          rd_ready;
  logic [31:0]   rd_pc;
  logic          rd_w;
  logic [4:0]    rd_rd;
  logic [31:0]   rd_res;
  logic          done;

  typedef struct {
    logic [31:0] pc;
    logic        w;
    logic [4:0]  rd;
    logic [31:0] res;
  } ent_t;

  ent_t q[$];
  int   m_drop;
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_w(in_w),
    .in_rd(in_rd), .in_res(in_res),
    .arm(arm), .abort(abort),
    .trig_pc(trig_pc), .post_cnt(post_cnt),
    .state(state), .count(count),
    .dropped(dropped),
    .trig_hit(trig_hit),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_w(rd_w),
    .rd_rd(rd_rd), .rd_res(rd_res),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc  = pc;
    e.w   = pc[2];
    e.rd  = pc[6:2] ^ 5'h3;
    e.res = pc * 3 + 32'h1000;
    return e;
  endfunction

  task automatic do_arm(input logic [31:0] tp,
                        input logic [CW-1:0] pc);
    arm = 1'b1; trig_pc = tp; post_cnt = pc;
    step();
    arm = 1'b0; trig_pc = '0; post_cnt = '0;
    q.delete();
    m_drop = 0;
    chk("arm_state", state, 1);
    chk("arm_count", count, 0);
  endtask

  task automatic retire(input logic [31:0] pc,
                        input bit rec,
                        input bit th);
    ent_t e;
    e = mk(pc);
    in_valid = 1'b1; in_pc = e.pc; in_w = e.w;
    in_rd = e.rd; in_res = e.res;
    step();
    in_valid = 1'b0;
    if (rec) begin
      q.push_back(e);
      if (q.size() > DEPTH) begin
        void'(q.pop_front());
        m_drop++;
      end
    end
    chk("trig_hit", trig_hit, th);
  endtask

  task automatic drain(input bit toggle);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    bit r;
    chk("pre_count", count, q.size());
    chk("pre_dropped", dropped, m_drop);
    while (q.size() > 0 && k < 200) begin
      r = toggle ? pat[k % 4] : 1'b1;
      k++;
      chk("rd_valid", rd_valid, 1);
      chk("rd_pc", rd_pc, q[0].pc);
      chk("rd_w", rd_w, q[0].w);
      chk("rd_rd", rd_rd, q[0].rd);
      chk("rd_res", rd_res, q[0].res);
      chk("drain_count", count, q.size());
      rd_ready = r;
      step();
      rd_ready = 1'b0;
      if (r) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          chk("done_pulse", done, 1);
          chk("end_state", state, 0);
          chk("end_rd_valid", rd_valid, 0);
        end else begin
          chk("no_early_done", done, 0);
        end
      end
    end
    chk("drain_bound", q.size(), 0);
    step();
    chk("done_cleared", done, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0;
    in_w = 1'b0; in_rd = '0; in_res = '0;
    arm = 1'b0; abort = 1'b0;
    trig_pc = '0; post_cnt = '0;
    rd_ready = 1'b0; m_drop = 0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_trig_hit", trig_hit, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_pc", rd_pc, 0);

    retire(32'h40, 1'b0, 1'b0);
    chk("idle_count", count, 0);

    do_arm(32'h40, 5'd3);
    for (int i = 0; i < 20; i++)
      retire(32'(i * 4), 1'b1, i == 16);
    chk("t1_state", state, 3);
    chk("t1_count", count, 16);
    chk("t1_dropped", dropped, 4);
    drain(1'b0);

    do_arm(32'h08, 5'd5);
    retire(32'h00, 1'b1, 1'b0);
    retire(32'h04, 1'b1, 1'b0);
    retire(32'h08, 1'b1, 1'b1);
    retire(32'h0C, 1'b1, 1'b0);
    chk("ab_post", state, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_state", state, 0);
    chk("ab_count", count, 0);
    chk("ab_rd_valid", rd_valid, 0);
    chk("ab_done", done, 0);

    do_arm(32'h10, 5'd2);
    retire(32'h00, 1'b1, 1'b0);
    arm = 1'b1; trig_pc = 32'h08;
    post_cnt = 5'd0;
    step();
    arm = 1'b0;
    chk("rearm_state", state, 1);
    retire(32'h04, 1'b1, 1'b0);
    retire(32'h08, 1'b1, 1'b0);
    chk("trig_kept", state, 1);
    retire(32'h0C, 1'b1, 1'b0);
    retire(32'h10, 1'b1, 1'b1);
    retire(32'h14, 1'b1, 1'b0);
    retire(32'h18, 1'b1, 1'b0);
    chk("t3_state", state, 3);
    retire(32'h1C, 1'b0, 1'b0);
    chk("t3_count", count, 7);
    chk("t3_frozen", state, 3);
    drain(1'b0);

    do_arm(32'h00, 5'd3);
    retire(32'h00, 1'b1, 1'b1);
    retire(32'h04, 1'b1, 1'b0);
    retire(32'h08, 1'b1, 1'b0);
    retire(32'h0C, 1'b1, 1'b0);
    chk("rs_state", state, 3);
    rd_ready = 1'b1;
    step(); step();
    rd_ready = 1'b0;
    chk("rs_count", count, 2);
    #2 reset = 1'b1;
    #1;
    chk("rs_async_state", state, 0);
    chk("rs_async_count", count, 0);
    chk("rs_rd_valid", rd_valid, 0);
    step();
    reset = 1'b0;
    step();
    chk("rs_done", done, 0);
    chk("rs_idle", state, 0);

    do_arm(32'h00, 5'd31);
    retire(32'h00, 1'b1, 1'b1);
    for (int i = 1; i < 15; i++)
      retire(32'(i * 4), 1'b1, 1'b0);
    chk("cl_post", state, 2);
    retire(32'h3C, 1'b1, 1'b0);
    chk("cl_state", state, 3);
    drain(1'b1);

    do_arm(32'h40, 5'd0);
    for (int i = 0; i <= 16; i++)
      retire(32'(i * 4), 1'b1, i == 16);
    chk("t2_state", state, 3);
    retire(32'h44, 1'b0, 1'b0);
    chk("t2_count", count, 16);
    chk("t2_last_pc", q[q.size() - 1].pc,
        32'h40);
    drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
